cr_fifo_pop_stream: RTL and testbench
=====================================

Name: cr_fifo_pop_stream

Overview:
- Reader-side companion to the dual-clock FIFO controller.
- Sits in the pop clock domain. It drives the controller's active-low pop request and captures RAM read data after a fixed read latency.
- Presents the words as a valid/ready stream, with a small skid buffer so a continuously ready sink gets one word per clock.
- Replaces ad-hoc pop logic in every consumer of the FIFO.

Parameters:
- pDataWidth, 8: width of RAM read data and stream data.
- pRdLatency, 1: clocks from the edge that samples PopReq_n=0 to RdData valid. Legal values are 1 and 2.
- pBufDepth, pRdLatency+1: skid buffer entries. This is the minimum for full throughput and must be at least pRdLatency+1.

Ports:
- Clk  in  1  pop-domain clock; same net as the FIFO controller Pop_clk.
- Rst_n  in  1  reset, synchronous, active-low.
- PopReq_n  out  1  pop request to the FIFO controller, active low.
- PopEmpty  in  1  controller empty flag.
- PopError  in  1  controller underrun flag.
- RdData  in  pDataWidth  RAM read-port data.
- Flush  in  1  synchronous discard of buffered and in-flight words.
- OutValid  out  1  stream word valid.
- OutReady  in  1  sink accepts the word.
- OutData  out  pDataWidth  stream word.
- Level  out  $clog2(pBufDepth+1)  words currently held in the skid buffer.
- Underrun  out  1  sticky error flag.

Behaviour:
- Reset
  - Rst_n is sampled on the rising edge of Clk only.
  - While Rst_n=0: PopReq_n=1, OutValid=0, OutData=0, Level=0, Underrun=0. The in-flight pipeline and buffer pointers are cleared.
  - Reset mid-operation discards all buffered and in-flight words. Integration must reset the FIFO controller pop side in the same cycle.
- Dequeue: deq = OutValid & OutReady. The head word is removed at that edge.
- Issue rule (combinational PopReq_n):
  - PopReq_n=0 iff Rst_n=1, Flush=0, PopEmpty=0 and (Level + inflight - deq) < pBufDepth.
  - The block never requests while PopEmpty=1.
- In-flight tracking
  - A pRdLatency-deep shift register of valid bits. Bit 0 loads (PopReq_n==0 & !Flush).
  - inflight = popcount of the shift register. Width rule: Level+inflight never exceeds pBufDepth.
- Capture: when the last stage is valid, RdData is written at the buffer tail in that cycle's edge.
- Skid buffer
  - Circular buffer of pBufDepth entries. Head and tail pointers wrap modulo pBufDepth.
  - OutData is the head entry, taken from registers with no combinational path from RdData.
  - OutValid = (Level != 0).
  - Simultaneous capture and deq leaves Level unchanged.
  - Capture into a full buffer is impossible by the issue rule. The assertion must fire if it happens.
- Stream rules
  - While OutValid=1 and OutReady=0, OutData is held stable.
  - OutValid never drops without deq or Flush.
- Latency: with an empty block and PopEmpty falling at cycle t:
  - PopReq_n=0 in cycle t.
  - OutValid=1 in cycle t+pRdLatency+1.
- Throughput: with OutReady held 1 and a non-empty FIFO, there is one word per clock after fill.
- Flush
  - At the edge where Flush=1: Level becomes 0, OutValid falls next cycle, and all in-flight valid bits are cleared.
  - Words that arrive on RdData afterwards from already-sampled pops are ignored.
  - No requests are issued during Flush. Flushed words are lost by design.
- Underrun:
  - Set on any edge where PopError=1.
  - Cleared only by reset.
- Ordering: words are delivered in exactly pop order. There is no duplication or loss except by Flush or reset.

Test Plan:
- Single word: FIFO holds 0xA5, OutReady=1.
  - Required: one PopReq_n low pulse; OutValid=1 for exactly one cycle with OutData=0xA5 at t+pRdLatency+1.
  - Required: PopReq_n then stays 1 while PopEmpty=1.
- Streaming: 16 words 0x00..0x0F, OutReady=1, pRdLatency=1.
  - Required: 16 consecutive OutValid cycles in order.
  - Required: PopReq_n low for 16 consecutive cycles.
- Backpressure: 8 words, OutReady=0 for 10 cycles, then 1.
  - Required: Level saturates at pBufDepth=2 and PopReq_n stays 1 while full.
  - Required: OutData holds 0x00 stable, then all 8 words are delivered in order with none lost.
- Alternating ready: OutReady toggles every cycle with pRdLatency=2 and 12 words.
  - Required: every word is delivered once, in order.
  - Required: Level never exceeds 3.
- Flush: flush mid-stream with 1 word buffered and 1 in flight.
  - Required: OutValid=0 the next cycle and the in-flight word is discarded.
  - Required: the next delivered word is the first word popped after Flush deasserts.
- Error/reset: pulse PopError for 1 cycle, then assert Rst_n=0 mid-stream.
  - Required: Underrun=1 and stays set until reset.
  - Required: after reset, PopReq_n=1, OutValid=0, Level=0, Underrun=0.

Source files
------------

// File: rtl/cr_fifo_pop_stream.sv
// cr_fifo_pop_stream: pops the dual-clock FIFO and re-times RAM read data into a valid/ready stream
module cr_fifo_pop_stream #(
    parameter int pDataWidth = 8,
    parameter int pRdLatency = 1,
    parameter int pBufDepth  = pRdLatency + 1
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    output logic                           PopReq_n,
    input  logic                           PopEmpty,
    input  logic                           PopError,
    input  logic [pDataWidth-1:0]          RdData,
    input  logic                           Flush,
    output logic                           OutValid,
    input  logic                           OutReady,
    output logic [pDataWidth-1:0]          OutData,
    output logic [$clog2(pBufDepth+1)-1:0] Level,
    output logic                           Underrun
);
    localparam int LW = $clog2(pBufDepth + 1);
    localparam int PW = pBufDepth > 1 ? $clog2(pBufDepth) : 1;
    logic [pRdLatency-1:0] pipe;
    logic [pDataWidth-1:0] mem [pBufDepth];
    logic [PW-1:0] head, tail;
    logic [LW:0] occ;
    logic deq, issue, capture;
    // occ counts every slot already promised: buffered words plus reads still in flight
    always_comb begin
        deq = OutValid & OutReady;
        capture = pipe[pRdLatency-1];
        occ = {1'b0, Level} + (LW+1)'($countones(pipe)) - (LW+1)'(deq);
        issue = Rst_n & ~Flush & ~PopEmpty & (occ < (LW+1)'(pBufDepth));
        PopReq_n = ~issue;
        OutValid = Level != '0;
        OutData = OutValid ? mem[head] : '0;
    end
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pipe <= '0;
            head <= '0;
            tail <= '0;
            Level <= '0;
            Underrun <= 1'b0;
        end else begin
            Underrun <= Underrun | PopError;
            pipe <= Flush ? '0 : (pipe << 1) | pRdLatency'(issue);
            if (Flush) begin
                head <= '0;
                tail <= '0;
                Level <= '0;
            end else begin
                if (capture)
                    tail <= tail == PW'(pBufDepth - 1) ? '0 : tail + 1'b1;
                if (deq)
                    head <= head == PW'(pBufDepth - 1) ? '0 : head + 1'b1;
                Level <= Level + LW'(capture) - LW'(deq);
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (Rst_n && !Flush && capture)
            mem[tail] <= RdData;
    end
    assert property (@(posedge Clk) disable iff (!Rst_n)
        !(capture && !Flush && Level == LW'(pBufDepth)));
endmodule

// File: tb/tb_cr_fifo_pop_stream.sv
// tb_cr_fifo_pop_stream: runs read latencies 1 and 2 side by side against a queue-based FIFO/RAM model
module tb_cr_fifo_pop_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, flush, out_ready, pop_error, hold, load_v;
    logic [7:0] load_d;
    logic [1:0] pop_req_n, pop_empty, out_valid, underrun;
    logic [7:0] rd_data [2];
    logic [7:0] out_data [2];
    logic [1:0] level [2];
    int checks = 0;
    int errors = 0;
    int delivered [2] = '{0, 0};
    int pending [2] = '{0, 0};
    int base [2];
    logic [1:0] got;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[lat%0d]: got %0h, expected %0h", name, k + 1, act, req);
        end
    endtask

    task automatic load(input logic [7:0] v);
        load_v = 1'b1;
        load_d = v;
        @(negedge clk);
        load_v = 1'b0;
    endtask

    task automatic chk_reset_state();
        for (int k = 0; k < 2; k++) begin
            chk("rst_req", k, pop_req_n[k], 1);
            chk("rst_valid", k, out_valid[k], 0);
            chk("rst_level", k, level[k], 0);
            chk("rst_underrun", k, underrun[k], 0);
            chk("rst_data", k, out_data[k], 0);
        end
    endtask

    task automatic mark();
        for (int k = 0; k < 2; k++) base[k] = delivered[k];
    endtask

    task automatic chk_drained(input string name, input int n);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_count"}, k, delivered[k] - base[k], n);
            chk({name, "_pending"}, k, pending[k], 0);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = g + 1;
        localparam int D = g + 2;
        logic [7:0] src [$];
        logic [7:0] exp_q [$];
        logic [7:0] dl [L];
        logic [7:0] w;
        logic [7:0] held;
        logic stall_prev = 1'b0;
        int src_n = 0;
        assign pop_empty[g] = hold | (src_n == 0);
        assign rd_data[g] = dl[L-1];
        cr_fifo_pop_stream #(.pDataWidth(8), .pRdLatency(L)) dut (
            .Clk(clk), .Rst_n(rst_n), .PopReq_n(pop_req_n[g]), .PopEmpty(pop_empty[g]),
            .PopError(pop_error), .RdData(rd_data[g]), .Flush(flush), .OutValid(out_valid[g]),
            .OutReady(out_ready), .OutData(out_data[g]), .Level(level[g]), .Underrun(underrun[g])
        );
        // FIFO contents, RAM read latency and the expected delivery order, all at the queue level
        always @(posedge clk) begin
            w = 8'($urandom);
            if (!rst_n) begin
                src.delete();
                exp_q.delete();
                src_n <= 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", g, out_valid[g], 1);
                    chk("stall_data", g, out_data[g], held);
                end
                chk("level_max", g, level[g] <= 2'(D), 1);
                if (out_valid[g] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word[lat%0d]: got %0h, expected none", L, out_data[g]);
                    end else
                        chk("data", g, out_data[g], exp_q.pop_front());
                    delivered[g]++;
                end
                if (flush) begin
                    chk("flush_noreq", g, pop_req_n[g], 1);
                    exp_q.delete();
                end
                if (!pop_req_n[g]) begin
                    chk("pop_nonempty", g, pop_empty[g], 0);
                    if (src.size() > 0) begin
                        w = src.pop_front();
                        exp_q.push_back(w);
                    end
                end
                if (load_v) src.push_back(load_d);
                src_n <= src.size();
                stall_prev = out_valid[g] && !out_ready && !flush;
                held = out_data[g];
            end
            dl[0] <= w;
            for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
            pending[g] = exp_q.size();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush = 0; out_ready = 0; pop_error = 0; hold = 1; load_v = 0; load_d = 0;
        repeat (3) @(negedge clk);
        #2;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1;
        // single word: one request, one valid cycle at t+L+1
        load(8'hA5);
        out_ready = 1;
        hold = 0;
        for (int c = 0; c < 6; c++) begin
            #2;
            for (int k = 0; k < 2; k++) begin
                chk("sw_req", k, pop_req_n[k], c == 0 ? 0 : 1);
                chk("sw_valid", k, out_valid[k], c == k + 2 ? 1 : 0);
                if (c == k + 2) chk("sw_data", k, out_data[k], 8'hA5);
            end
            @(negedge clk);
        end
        // streaming 16 words at full rate
        hold = 1;
        mark();
        for (int i = 0; i < 16; i++) load(8'(i));
        hold = 0;
        for (int c = 0; c < 21; c++) begin
            #2;
            for (int k = 0; k < 2; k++) begin
                chk("st_req", k, pop_req_n[k], c < 16 ? 0 : 1);
                chk("st_valid", k, out_valid[k], (c >= k + 2 && c <= k + 17) ? 1 : 0);
            end
            @(negedge clk);
        end
        chk_drained("stream", 16);
        // backpressure: buffer saturates, head word held
        hold = 1;
        out_ready = 0;
        mark();
        for (int i = 0; i < 8; i++) load(8'(i));
        hold = 0;
        repeat (10) @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("bp_level", k, level[k], k + 2);
            chk("bp_req", k, pop_req_n[k], 1);
            chk("bp_valid", k, out_valid[k], 1);
            chk("bp_data", k, out_data[k], 8'h00);
        end
        @(negedge clk);
        out_ready = 1;
        repeat (20) @(negedge clk);
        chk_drained("bp", 8);
        // alternating ready
        hold = 1;
        out_ready = 0;
        mark();
        for (int i = 0; i < 12; i++) load(8'h20 + 8'(i));
        hold = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = c[0];
            @(negedge clk);
        end
        out_ready = 1;
        repeat (10) @(negedge clk);
        chk_drained("alt", 12);
        // flush with one word buffered and one in flight
        hold = 1;
        out_ready = 0;
        mark();
        for (int i = 0; i < 6; i++) load(8'h40 + 8'(i));
        hold = 0;
        repeat (2) @(negedge clk);
        flush = 1;
        #2;
        for (int k = 0; k < 2; k++) chk("fl_req", k, pop_req_n[k], 1);
        @(negedge clk);
        flush = 0;
        out_ready = 1;
        #2;
        for (int k = 0; k < 2; k++) chk("fl_valid", k, out_valid[k], 0);
        got = 2'b00;
        for (int c = 0; c < 12 && got != 2'b11; c++) begin
            for (int k = 0; k < 2; k++)
                if (!got[k] && out_valid[k]) begin
                    chk("fl_next", k, out_data[k], 8'h42);
                    got[k] = 1'b1;
                end
            @(negedge clk);
            #2;
        end
        for (int k = 0; k < 2; k++) chk("fl_timeout", k, got[k], 1);
        repeat (15) @(negedge clk);
        chk_drained("flush", 4);
        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom % 4) != 0;
            load_v = ($urandom % 3) == 0;
            load_d = 8'($urandom);
            flush = ($urandom % 40) == 0;
            hold = ($urandom % 10) == 0;
            @(negedge clk);
        end
        flush = 0; hold = 0; load_v = 0; out_ready = 1;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 2; k++) chk("rand_pending", k, pending[k], 0);
        // underrun then reset mid-stream
        hold = 1;
        for (int i = 0; i < 8; i++) load(8'h60 + 8'(i));
        hold = 0;
        repeat (2) @(negedge clk);
        pop_error = 1;
        @(negedge clk);
        pop_error = 0;
        for (int c = 0; c < 3; c++) begin
            #2;
            for (int k = 0; k < 2; k++) chk("underrun_set", k, underrun[k], 1);
            @(negedge clk);
        end
        rst_n = 0;
        @(negedge clk);
        #2;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_underrun", k, underrun[k], 0);
            chk("post_rst_valid", k, out_valid[k], 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
